messbauer_channel_sequencer: RTL and testbench
==============================================

Name: messbauer_channel_sequencer

Overview:
Sequences the Messbauer velocity sweep and the channel timing that goes with it. It drives the saw-tooth generator's step and direction controls, divides the sweep into forward-slope and reverse-slope channels, and emits per-channel strobes with a channel index for the spectrum accumulator. It sits between the run-control logic and the saw-tooth generator / channel accumulator pair.

Parameters:
CHANNELS, 512, total channels per sweep; even, power of two; first half forward, second half reverse
TICKS_PER_CHANNEL, 16, clk cycles of dwell per channel; >= 2
CYCLE_W, 16, width of the completed-sweep counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start_req  input  1  one-cycle pulse; begin sweeping (ignored unless IDLE)
stop_req  input  1  one-cycle pulse; finish current sweep, then stop
saw_clear  output  1  one-cycle pulse; zeroes the saw-tooth generator
saw_step  output  1  one-cycle pulse; advance the saw-tooth by one step
saw_dir  output  1  0 = ramp up (forward), 1 = ramp down (reverse)
sweep_start  output  1  one-cycle pulse at the start of each sweep (start/sync line)
channel_strobe  output  1  one-cycle pulse at the last tick of each channel dwell
channel_index  output  log2(CHANNELS)  current channel number
reverse_slope  output  1  high while channel_index >= CHANNELS/2
busy  output  1  high in any state other than IDLE
sweep_count  output  CYCLE_W  completed sweeps since start; saturates at all-ones

Behaviour:
- Reset (synchronous, highest priority, any state): state=IDLE; all pulses 0; channel_index=0; saw_dir=0; reverse_slope=0; busy=0; sweep_count=0; tick counter=0; stop_pending=0.
- FSM states: IDLE, SYNC, FORWARD, REVERSE.
- IDLE: start_req -> SYNC next cycle. stop_req is ignored.
- SYNC (exactly 1 cycle): saw_clear=1, sweep_start=1, channel_index=0, tick=0. Next state: FORWARD.
- FORWARD/REVERSE: tick counts 0..TICKS_PER_CHANNEL-1.
  - At tick==TICKS_PER_CHANNEL-1: channel_strobe=1 and saw_step=1 in the same cycle; tick wraps to 0; channel_index increments.
- FORWARD -> REVERSE on the strobe of channel CHANNELS/2-1. saw_dir and reverse_slope go 1 in the cycle channel_index becomes CHANNELS/2.
- REVERSE, strobe of channel CHANNELS-1:
  - channel_index wraps to 0; sweep_count increments (saturating).
  - If stop_pending=1, go to IDLE and clear stop_pending. Otherwise go to SYNC.
  - saw_dir and reverse_slope return to 0 on the same transition.
- stop_req while busy sets stop_pending; the stop takes effect only at sweep end, so partial sweeps are never produced.
- stop_req and start_req in the same cycle from IDLE: start wins, and stop_pending is set.
- start_req while busy: ignored.
- Latency: start_req to sweep_start is 1 cycle; sweep_start to first channel_strobe is TICKS_PER_CHANNEL cycles.
- Sweep period: 1 + CHANNELS*TICKS_PER_CHANNEL cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Widths: tick counter is clog2(TICKS_PER_CHANNEL). Increments are modulo their width, except sweep_count, which saturates.

Decomposition:
- Shared package messbauer_pkg: FSM state encoding constants (IDLE=0, SYNC=1, FORWARD=2, REVERSE=3) and the CHANNELS/2 midpoint helper.
- One sub-module: messbauer_dwell_timer. It holds the tick counter and a terminal-count pulse, with clear/enable inputs.
- The FSM, channel counter and sweep counter stay in the top module.

Test Plan:
- Use CHANNELS=8, TICKS_PER_CHANNEL=4.
- Reset mid-REVERSE at channel 6 -> next cycle: state IDLE, channel_index=0, saw_dir=0, busy=0, sweep_count=0.
- start_req at cycle T -> sweep_start and saw_clear high at T+1 only; first channel_strobe at T+5; strobes every 4 cycles thereafter.
- Full sweep -> 8 strobes, 8 saw_step pulses; reverse_slope rises exactly when channel_index=4; next sweep_start follows 33 cycles after the previous; sweep_count=1.
- stop_req during channel 2 -> sweep completes through channel 7, then IDLE, busy=0, sweep_count=1, no further sweep_start.
- Simultaneous start_req and stop_req in IDLE -> exactly one sweep runs, then IDLE.
- start_req while busy -> no extra sweep_start and no timing disturbance.
- CYCLE_W=2, run 5 sweeps -> sweep_count saturates at 3.

Source files
------------

// File: rtl/messbauer_pkg.sv
// Shared definitions for the Messbauer channel sequencer: FSM encoding and sweep helpers.
package messbauer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        FORWARD = 2'd2,
        REVERSE = 2'd3
    } seq_state_e;

    // Channel count of one slope; the reverse slope begins at this index.
    function automatic int unsigned half_channels(input int unsigned channels);
        return channels >> 1;
    endfunction

endpackage

// File: rtl/messbauer_dwell_timer.sv
// Per-channel dwell counter; terminal is a registered pulse during the last tick of each dwell.
module messbauer_dwell_timer #(
    parameter int unsigned TICKS = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int unsigned TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS - 1);

    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;

    always_comb begin
        tick_d = tick_q;
        if (clear) begin
            tick_d = '0;
        end else if (enable) begin
            tick_d = (tick_q == LAST_TICK) ? '0 : tick_q + TICK_W'(1);
        end
    end

    // Terminal is registered from the upcoming tick value so it lines up with tick == LAST_TICK.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q   <= '0;
            terminal <= 1'b0;
        end else begin
            tick_q   <= tick_d;
            terminal <= ~clear & enable & (tick_d == LAST_TICK);
        end
    end

endmodule

// File: rtl/messbauer_channel_sequencer.sv
// Sequences the Messbauer velocity sweep: saw-tooth control, per-channel strobes and sweep counting.
module messbauer_channel_sequencer
    import messbauer_pkg::*;
#(
    parameter int unsigned CHANNELS          = 512,
    parameter int unsigned TICKS_PER_CHANNEL = 16,
    parameter int unsigned CYCLE_W           = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_req,
    input  logic                        stop_req,
    output logic                        saw_clear,
    output logic                        saw_step,
    output logic                        saw_dir,
    output logic                        sweep_start,
    output logic                        channel_strobe,
    output logic [$clog2(CHANNELS)-1:0] channel_index,
    output logic                        reverse_slope,
    output logic                        busy,
    output logic [CYCLE_W-1:0]          sweep_count
);

    localparam int unsigned CH_W = $clog2(CHANNELS);
    localparam int unsigned MID  = half_channels(CHANNELS);
    localparam logic [CH_W-1:0] MID_LAST = CH_W'(MID - 1);
    localparam logic [CH_W-1:0] CH_LAST  = CH_W'(CHANNELS - 1);

    seq_state_e state_q;
    seq_state_e state_d;
    logic       stop_pending;
    logic       dwell_done;
    logic       timer_clear_c;
    logic       timer_en_c;
    logic       mid_cross_c;
    logic       sweep_end_c;
    logic       saw_clear_d;
    logic       sweep_start_d;
    logic       busy_d;
    logic       reverse_d;

    assign timer_en_c    = (state_q == FORWARD) || (state_q == REVERSE);
    assign timer_clear_c = ~timer_en_c;
    assign mid_cross_c   = (state_q == FORWARD) && dwell_done && (channel_index == MID_LAST);
    assign sweep_end_c   = (state_q == REVERSE) && dwell_done && (channel_index == CH_LAST);

    messbauer_dwell_timer #(
        .TICKS (TICKS_PER_CHANNEL)
    ) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear_c),
        .enable   (timer_en_c),
        .terminal (dwell_done)
    );

    // Both pulses come straight from the registered terminal count.
    assign channel_strobe = dwell_done;
    assign saw_step       = dwell_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_req) state_d = SYNC;
            SYNC:    state_d = FORWARD;
            FORWARD: if (mid_cross_c) state_d = REVERSE;
            REVERSE: if (sweep_end_c) state_d = stop_pending ? IDLE : SYNC;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        saw_clear_d   = 1'b0;
        sweep_start_d = 1'b0;
        busy_d        = 1'b0;
        reverse_d     = 1'b0;
        saw_clear_d   = (state_d == SYNC);
        sweep_start_d = (state_d == SYNC);
        busy_d        = (state_d != IDLE);
        reverse_d     = (state_d == REVERSE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            saw_clear     <= 1'b0;
            sweep_start   <= 1'b0;
            busy          <= 1'b0;
            saw_dir       <= 1'b0;
            reverse_slope <= 1'b0;
        end else begin
            saw_clear     <= saw_clear_d;
            sweep_start   <= sweep_start_d;
            busy          <= busy_d;
            saw_dir       <= reverse_d;
            reverse_slope <= reverse_d;
        end
    end

    // A stop only takes effect at sweep end; a sweep ending into IDLE consumes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stop_pending <= 1'b0;
        end else if (sweep_end_c && stop_pending) begin
            stop_pending <= 1'b0;
        end else if (stop_req && ((state_q != IDLE) || start_req)) begin
            stop_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            channel_index <= '0;
        end else if ((state_d == SYNC) || (state_d == IDLE)) begin
            channel_index <= '0;
        end else if (dwell_done) begin
            channel_index <= channel_index + CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_count <= '0;
        end else if (sweep_end_c && (sweep_count != {CYCLE_W{1'b1}})) begin
            sweep_count <= sweep_count + CYCLE_W'(1);
        end
    end

endmodule

// File: tb/tb_messbauer_channel_sequencer.sv
// Self-checking bench: sweep-timeline model compared every cycle, plus directed literal checks.
module tb_messbauer_channel_sequencer;

    localparam int CH        = 8;
    localparam int TPC       = 4;
    localparam int CW        = 2;
    localparam int SWEEP_LEN = 1 + CH * TPC;
    localparam int CNT_MAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_req = 1'b0;
    logic          stop_req = 1'b0;
    logic          saw_clear, saw_step, saw_dir, sweep_start, channel_strobe;
    logic [2:0]    channel_index;
    logic          reverse_slope, busy;
    logic [CW-1:0] sweep_count;

    messbauer_channel_sequencer #(
        .CHANNELS          (CH),
        .TICKS_PER_CHANNEL (TPC),
        .CYCLE_W           (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_req      (start_req),
        .stop_req       (stop_req),
        .saw_clear      (saw_clear),
        .saw_step       (saw_step),
        .saw_dir        (saw_dir),
        .sweep_start    (sweep_start),
        .channel_strobe (channel_strobe),
        .channel_index  (channel_index),
        .reverse_slope  (reverse_slope),
        .busy           (busy),
        .sweep_count    (sweep_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Model: a sweep is a timeline offset k from its sweep_start cycle.
    bit m_busy = 0, m_stop = 0;
    int m_s = 0, m_count = 0;
    int e_clear, e_ss, e_strobe, e_ch, e_dir, e_busy, e_cnt;

    always @(posedge clk) begin
        int n, k, j;
        ncyc = ncyc + 1;
        n = ncyc;
        if (reset) begin
            m_busy = 0; m_stop = 0; m_count = 0; chk_en = 1;
        end else if (!m_busy) begin
            if (start_req) begin
                m_busy = 1; m_s = n; m_stop = stop_req;
            end
        end else if ((n - 1 - m_s) == SWEEP_LEN - 1) begin
            if (m_count < CNT_MAX) m_count = m_count + 1;
            if (m_stop) begin
                m_busy = 0; m_stop = 0;
            end else begin
                m_s = n; m_stop = stop_req;
            end
        end else if (stop_req) begin
            m_stop = 1;
        end
        e_clear = 0; e_ss = 0; e_strobe = 0; e_ch = 0; e_dir = 0;
        e_busy = m_busy; e_cnt = m_count;
        if (m_busy) begin
            k = n - m_s;
            if (k == 0) begin
                e_clear = 1; e_ss = 1;
            end else begin
                j = k - 1;
                e_ch = j / TPC;
                e_strobe = ((j % TPC) == TPC - 1) ? 1 : 0;
                e_dir = (e_ch >= CH / 2) ? 1 : 0;
            end
        end
    end

    // Compare process plus event bookkeeping for directed checks.
    int ss_cnt = 0, last_ss = -1, prev_ss = -1, first_strobe = -1;
    int strobe_cnt = 0, step_cnt = 0, rev_ch = -1;
    bit rev_prev = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("saw_clear", int'(saw_clear), e_clear);
            chk("sweep_start", int'(sweep_start), e_ss);
            chk("channel_strobe", int'(channel_strobe), e_strobe);
            chk("saw_step", int'(saw_step), e_strobe);
            chk("channel_index", int'(channel_index), e_ch);
            chk("saw_dir", int'(saw_dir), e_dir);
            chk("reverse_slope", int'(reverse_slope), e_dir);
            chk("busy", int'(busy), e_busy);
            chk("sweep_count", int'(sweep_count), e_cnt);
            if (sweep_start) begin
                ss_cnt++; prev_ss = last_ss; last_ss = ncyc; first_strobe = -1;
            end
            if (channel_strobe) begin
                strobe_cnt++;
                if (first_strobe < 0) first_strobe = ncyc;
            end
            if (saw_step) step_cnt++;
            if (reverse_slope && !rev_prev) rev_ch = int'(channel_index);
            rev_prev = reverse_slope;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t, s0, st0, sp0;
        bit ok;

        // Reset and idle state
        step(3);
        reset = 1'b0;
        step(1);
        chk("lit_reset_busy", int'(busy), 0);
        chk("lit_reset_count", int'(sweep_count), 0);
        chk("lit_reset_ch", int'(channel_index), 0);

        // Start latency and first strobe
        t = ncyc; st0 = strobe_cnt; sp0 = step_cnt;
        start_req = 1'b1;
        step(1);
        start_req = 1'b0;
        chk("lit_ss_at_T1", int'(sweep_start), 1);
        chk("lit_clear_at_T1", int'(saw_clear), 1);
        step(1);
        chk("lit_ss_low_T2", int'(sweep_start), 0);
        step(4);
        chk("lit_first_strobe", first_strobe, t + 5);

        // Full sweep until the next sweep_start
        ok = 0;
        for (int i = 0; i < 80; i++) begin
            if (ss_cnt == 2) begin ok = 1; break; end
            step(1);
        end
        chk("lit_wait_sweep2", int'(ok), 1);
        chk("lit_sweep_period", last_ss - prev_ss, 33);
        chk("lit_strobes_per_sweep", strobe_cnt - st0, 8);
        chk("lit_steps_per_sweep", step_cnt - sp0, 8);
        chk("lit_rev_rise_ch", rev_ch, 4);
        chk("lit_count_one", int'(sweep_count), 1);

        // Stop during channel 2, plus an ignored start while busy
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (channel_index == 3'd2) begin ok = 1; break; end
            step(1);
        end
        chk("lit_wait_ch2", int'(ok), 1);
        stop_req = 1'b1;
        step(1);
        stop_req = 1'b0;
        step(3);
        start_req = 1'b1;
        step(1);
        start_req = 1'b0;
        ok = 0;
        for (int i = 0; i < 80; i++) begin
            if (!busy) begin ok = 1; break; end
            step(1);
        end
        chk("lit_wait_stop_idle", int'(ok), 1);
        chk("lit_stop_count", int'(sweep_count), 2);
        step(40);
        chk("lit_no_more_sweeps", ss_cnt, 2);
        chk("lit_stop_strobes", strobe_cnt - st0, 16);

        // Simultaneous start and stop from IDLE
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        s0 = ss_cnt;
        start_req = 1'b1; stop_req = 1'b1;
        step(1);
        start_req = 1'b0; stop_req = 1'b0;
        ok = 0;
        for (int i = 0; i < 80; i++) begin
            if (!busy) begin ok = 1; break; end
            step(1);
        end
        chk("lit_wait_single_idle", int'(ok), 1);
        step(40);
        chk("lit_single_sweep", ss_cnt - s0, 1);
        chk("lit_single_count", int'(sweep_count), 1);

        // Saturation after five sweeps, then reset mid-reverse at channel 6
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        start_req = 1'b1;
        step(1);
        start_req = 1'b0;
        step(165);
        chk("lit_sat_count", int'(sweep_count), 3);
        chk("lit_sat_busy", int'(busy), 1);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (channel_index == 3'd6) begin ok = 1; break; end
            step(1);
        end
        chk("lit_wait_ch6", int'(ok), 1);
        chk("lit_ch6_reverse", int'(reverse_slope), 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("lit_rst_busy", int'(busy), 0);
        chk("lit_rst_ch", int'(channel_index), 0);
        chk("lit_rst_dir", int'(saw_dir), 0);
        chk("lit_rst_count", int'(sweep_count), 0);
        step(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
